ro_trace_capture: RTL and testbench
===================================

// Module: ro_trace_capture
// PURPOSE
//  Downstream consumer of the 16x32-bit ring-oscillator adder tree. Takes the
//  36-bit aggregate sensor sum, waits for a trigger plus programmable delay,
//  averages 2^avg_shift consecutive sums per point and stores DEPTH points in
//  an on-chip trace buffer. The trace is then streamed out over a valid/ready
//  port to the UART/host readout path.
// PARAMETERS
//  SUM_W    36   width of the adder-tree sum and of each stored trace point
//  DEPTH    256  trace points per capture (power of two)
//  ADDR_W   8    log2(DEPTH)
//  DELAY_W  16   width of the trigger-to-capture delay counter
// PORTS
//  clk           in   1        system clock
//  rst           in   1        synchronous reset, active-high
//  sum_in        in   SUM_W    adder-tree output (z)
//  sum_valid     in   1        sum_in is a new sample this cycle
//  arm           in   1        pulse: start a capture sequence (IDLE only)
//  trigger       in   1        level/pulse from crypto core: start of operation
//  delay_cycles  in   DELAY_W  clk cycles between trigger and first sample
//  avg_shift     in   2        samples averaged per point = 2^avg_shift (1..8)
//  busy          out  1        state != IDLE
//  done          out  1        1-cycle pulse after last trace point read out
//  rd_data       out  SUM_W    trace point at read pointer
//  rd_valid      out  1        rd_data valid
//  rd_ready      in   1        consumer accepts rd_data
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, rd_valid=0, rd_data=0; all counters,
//   pointers, accumulator cleared. Buffer contents undefined after reset.
//  States: IDLE -> ARMED -> (DELAY) -> CAPTURE -> READOUT -> IDLE.
//  IDLE: arm=1 -> ARMED; delay_cycles and avg_shift latched that cycle; later
//   changes to those inputs ignored until next arm.
//  ARMED: trigger=1 -> DELAY with cnt=delay, or CAPTURE directly if delay==0.
//   trigger in any other state ignored; arm outside IDLE ignored.
//  DELAY: exactly delay clk cycles spent in DELAY, then CAPTURE (sum_valid
//   not counted here).
//  CAPTURE: only cycles with sum_valid=1 count. acc (SUM_W+3 bits) += sum_in;
//   on the 2^avg_shift-th sample, mem[wr_ptr] <= (acc+sum_in) >> avg_shift
//   (floor, low SUM_W bits), acc<=0, wr_ptr++. After DEPTH-th write -> READOUT.
//   sum_valid=0 cycles leave acc and counts unchanged.
//  READOUT: one-cycle memory read latency; rd_valid first asserts the 2nd cycle
//   in READOUT with rd_data=mem[0]. Handshake when rd_valid&rd_ready: advance
//   rd_ptr; next point presented with no bubble (prefetch). rd_data/rd_valid
//   held stable while rd_valid&!rd_ready. After DEPTH-th handshake: rd_valid=0,
//   done=1 for one cycle, state=IDLE (done and IDLE coincide).
//  busy=1 in every state except IDLE, combinational from state register.
//  rst asserted mid-operation: immediate return to IDLE per reset values; no
//   done pulse; partial trace discarded.
//  No overflow possible: max acc = 8*(2^SUM_W-1) < 2^(SUM_W+3).
// TESTING
//  1 delay=0, shift=0, ramp sum_in=0..255 every cycle, rd_ready=1 -> rd_data
//    0..255 in order, done after 256th handshake, busy low with done.
//  2 delay=10: trigger at cycle T -> first sample accepted at T+11 (verify by
//    ramp value read as point 0).
//  3 shift=2, sum_in = 4,8,12,16 repeating -> every point = 10; shift=3 with
//    sum_in=2^36-1 constant -> every point = 2^36-1 (no overflow).
//  4 sum_valid toggling 1/0 and random rd_ready stalls -> same data as (1),
//    rd_data stable during stalls, no lost/duplicated points.
//  5 arm/trigger during CAPTURE and READOUT, trigger while IDLE -> no effect.
//  6 rst mid-CAPTURE and mid-READOUT -> next cycle IDLE, outputs at reset
//    values; fresh arm/trigger produces full correct trace.

Source files
------------

// File: rtl/ro_trace_capture_if.sv
`default_nettype none
// ============================================================================
//  Module      : ro_trace_capture_if
//  Description : Bundle of sensor-sum input, capture control and trace
//                readout stream for ro_trace_capture.
//                master : producer/controller side (drives sum, arm, trigger,
//                         configuration and rd_ready; observes status/readout)
//                slave  : the capture block itself
//  Signals     : sum_in/sum_valid       adder-tree sample stream
//                arm/trigger            capture sequencing
//                delay_cycles/avg_shift configuration, latched on arm
//                busy/done              status
//                rd_data/rd_valid/rd_ready trace readout stream
//  Revision    : 1.0  initial release
// ============================================================================
interface ro_trace_capture_if #(
    parameter int SUM_W   = 36,
    parameter int DELAY_W = 16
);
    logic [SUM_W-1:0]   sum_in;
    logic               sum_valid;
    logic               arm;
    logic               trigger;
    logic [DELAY_W-1:0] delay_cycles;
    logic [1:0]         avg_shift;
    logic               busy;
    logic               done;
    logic [SUM_W-1:0]   rd_data;
    logic               rd_valid;
    logic               rd_ready;

    modport master (
        output sum_in, sum_valid, arm, trigger, delay_cycles, avg_shift, rd_ready,
        input  busy, done, rd_data, rd_valid
    );

    modport slave (
        input  sum_in, sum_valid, arm, trigger, delay_cycles, avg_shift, rd_ready,
        output busy, done, rd_data, rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/ro_trace_capture.sv
`default_nettype none
// ============================================================================
//  Module      : ro_trace_capture
//  Description : Trace capture for the ring-oscillator adder-tree sum. After
//                arm and trigger (plus a programmable delay) it averages
//                2^avg_shift consecutive valid sums per point, stores DEPTH
//                points, then streams them out over a valid/ready port.
//  Ports       : clk  - system clock
//                rst  - synchronous reset, active-high
//                bus  - ro_trace_capture_if.slave (sum input, control,
//                       status and trace readout stream)
//  Revision    : 1.0  initial release
// ============================================================================
module ro_trace_capture #(
    parameter int SUM_W   = 36,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int DELAY_W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    ro_trace_capture_if.slave bus
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_armed   = 3'd1;
    localparam logic [2:0] c_st_delay   = 3'd2;
    localparam logic [2:0] c_st_capture = 3'd3;
    localparam logic [2:0] c_st_readout = 3'd4;

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    logic [2:0]         r_state;
    logic [DELAY_W-1:0] r_cnt;
    logic [1:0]         r_shift;
    logic [SUM_W+2:0]   r_acc;
    logic [2:0]         r_smp;
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [SUM_W-1:0]   r_rd_data;
    logic               r_rd_valid;
    logic               r_done;
    logic [SUM_W-1:0]   r_mem [DEPTH];

    logic [SUM_W+2:0]   w_sum;
    logic [SUM_W-1:0]   w_point;
    logic [2:0]         w_smp_max;
    logic               w_smp_last;
    logic               w_wr_en;
    logic               w_hs;

    // Accumulator is 3 bits wider than a sample, so 8 full-scale sums fit.
    assign w_sum      = r_acc + {3'b000, bus.sum_in};
    assign w_point    = SUM_W'(w_sum >> r_shift);
    assign w_smp_max  = 3'((4'd1 << r_shift) - 4'd1);
    assign w_smp_last = (r_smp == w_smp_max);
    assign w_wr_en    = (r_state == c_st_capture) && bus.sum_valid && w_smp_last;
    assign w_hs       = r_rd_valid && bus.rd_ready;

    // Trace buffer: plain RAM, no reset on contents.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_point;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_acc      <= '0;
            r_smp      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.arm) begin
                        r_state  <= c_st_armed;
                        r_cnt    <= bus.delay_cycles;
                        r_shift  <= bus.avg_shift;
                        r_acc    <= '0;
                        r_smp    <= '0;
                        r_wr_ptr <= '0;
                        r_rd_ptr <= '0;
                    end
                end
                c_st_armed: begin
                    if (bus.trigger) begin
                        r_state <= (r_cnt == '0) ? c_st_capture : c_st_delay;
                    end
                end
                c_st_delay: begin
                    // Entered with r_cnt >= 1; leave after exactly r_cnt cycles.
                    r_cnt <= r_cnt - DELAY_W'(1);
                    if (r_cnt == DELAY_W'(1)) begin
                        r_state <= c_st_capture;
                    end
                end
                c_st_capture: begin
                    if (bus.sum_valid) begin
                        if (w_smp_last) begin
                            r_acc    <= '0;
                            r_smp    <= '0;
                            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                            if (r_wr_ptr == c_last_addr) begin
                                r_state <= c_st_readout;
                            end
                        end else begin
                            r_acc <= w_sum;
                            r_smp <= r_smp + 3'd1;
                        end
                    end
                end
                c_st_readout: begin
                    // rd_valid is low only in the first readout cycle: that
                    // cycle issues the read of point 0. Afterwards each
                    // handshake fetches the following point so the stream
                    // runs without bubbles.
                    if (!r_rd_valid) begin
                        r_rd_data  <= r_mem[r_rd_ptr];
                        r_rd_valid <= 1'b1;
                    end else if (w_hs) begin
                        if (r_rd_ptr == c_last_addr) begin
                            r_rd_valid <= 1'b0;
                            r_done     <= 1'b1;
                            r_rd_ptr   <= '0;
                            r_state    <= c_st_idle;
                        end else begin
                            r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
                            r_rd_data <= r_mem[r_rd_ptr + ADDR_W'(1)];
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.busy     = (r_state != c_st_idle);
    assign bus.done     = r_done;
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_ro_trace_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ro_trace_capture
//  Description : Self-checking bench for ro_trace_capture. A table of capture
//                scenarios is run against a reference model that groups the
//                accepted samples and averages them; extra sequences cover
//                reset during capture/readout and stray trigger in idle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ro_trace_capture;

    localparam int SUM_W   = 36;
    localparam int DEPTH   = 256;
    localparam int ADDR_W  = 8;
    localparam int DELAY_W = 16;
    localparam logic [63:0] c_mask = (64'd1 << SUM_W) - 64'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ro_trace_capture_if #(.SUM_W(SUM_W), .DELAY_W(DELAY_W)) bus ();

    ro_trace_capture #(
        .SUM_W   (SUM_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .DELAY_W (DELAY_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          delay;
        int          shift;
        int          smode;   // 0 ramp, 1 pattern 4/8/12/16, 2 all ones, 3 random
        int          vmode;   // 0 always, 1 toggling, 2 random
        int          rmode;   // 0 always ready, 1 random stalls
        bit          chk_p0;
        logic [63:0] exp_p0;
        bit          chk_all;
        logic [63:0] exp_all;
    } rec_t;

    rec_t tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [SUM_W-1:0] sum_val(input int smode, input int j);
        logic [63:0] rnd;
        rnd = {$urandom(), $urandom()};
        case (smode)
            0:       return SUM_W'(j - 1);
            1:       return SUM_W'(4 * (((j - 1) % 4) + 1));
            2:       return '1;
            default: return rnd[SUM_W-1:0];
        endcase
    endfunction

    function automatic bit valid_val(input int vmode, input int j);
        case (vmode)
            0:       return 1'b1;
            1:       return (j % 2) == 1;
            default: return ($urandom() % 2) == 0;
        endcase
    endfunction

    task automatic do_reset();
        bus.arm = 1'b0; bus.trigger = 1'b0; bus.sum_valid = 1'b0;
        bus.rd_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_capture(input rec_t r, input int abort_kind, input int abort_n, input string tag);
        logic [63:0]      samples [$];
        logic [63:0]      pts [$];
        logic [63:0]      got [$];
        logic [SUM_W-1:0] s;
        logic [63:0]      a;
        int               nsamp;
        int               grp;
        int               last_j;
        int               idx;
        int               n_bad;
        bit               v;
        bit               rdy;
        nsamp  = DEPTH << r.shift;
        grp    = 1 << r.shift;
        last_j = -1;
        idx    = 0;

        @(posedge clk); #1;
        bus.arm = 1'b1; bus.trigger = 1'b0;
        bus.delay_cycles = DELAY_W'(r.delay);
        bus.avg_shift    = 2'(r.shift);
        @(negedge clk);
        check({tag, " busy_idle"}, 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        // Configuration must have been latched at arm time.
        bus.arm = 1'b0;
        bus.delay_cycles = DELAY_W'($urandom());
        bus.avg_shift    = 2'($urandom());
        @(negedge clk);
        check({tag, " busy_armed"}, 64'(bus.busy), 64'd1);
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
            bus.arm = ($urandom() % 2) == 0;
        end
        @(posedge clk); #1;
        bus.arm = 1'b0; bus.trigger = 1'b1;   // trigger cycle j = 0
        @(negedge clk);

        for (int j = 1; j < 40000; j++) begin
            @(posedge clk); #1;
            if ((abort_kind == 1 && last_j < 0 && samples.size() >= abort_n) ||
                (abort_kind == 2 && idx >= abort_n)) begin
                bus.arm = 1'b0; bus.trigger = 1'b0; rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check({tag, " rst_busy"},     64'(bus.busy),     64'd0);
                check({tag, " rst_done"},     64'(bus.done),     64'd0);
                check({tag, " rst_rd_valid"}, 64'(bus.rd_valid), 64'd0);
                check({tag, " rst_rd_data"},  64'(bus.rd_data),  64'd0);
                return;
            end
            v   = valid_val(r.vmode, j);
            s   = sum_val(r.smode, j);
            rdy = (r.rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            bus.sum_valid = v;
            bus.sum_in    = s;
            bus.rd_ready  = rdy;
            // Stray control activity; only ever harmless outside IDLE.
            bus.trigger   = ($urandom() % 8) == 0;
            bus.arm       = (idx < DEPTH) && (($urandom() % 8) == 0);
            if (last_j < 0 && j >= r.delay + 1 && v) begin
                samples.push_back(64'(s));
                if (samples.size() == nsamp) begin
                    last_j = j;
                    for (int p = 0; p < DEPTH; p++) begin
                        a = 64'd0;
                        for (int k = 0; k < grp; k++) a += samples[p * grp + k];
                        pts.push_back((a >> r.shift) & c_mask);
                    end
                end
            end
            @(negedge clk);
            if (last_j < 0 || j <= last_j) begin
                check({tag, " cap_busy"},     64'(bus.busy),     64'd1);
                check({tag, " cap_rd_valid"}, 64'(bus.rd_valid), 64'd0);
            end else if (j == last_j + 1) begin
                check({tag, " ro_first_busy"},  64'(bus.busy),     64'd1);
                check({tag, " ro_first_valid"}, 64'(bus.rd_valid), 64'd0);
            end else if (idx < DEPTH) begin
                check({tag, " ro_valid"}, 64'(bus.rd_valid), 64'd1);
                check({tag, " ro_done"},  64'(bus.done),     64'd0);
                check({tag, $sformatf(" ro_data[%0d]", idx)}, 64'(bus.rd_data), pts[idx]);
                if (rdy) begin
                    got.push_back(64'(bus.rd_data));
                    idx++;
                end
            end else begin
                check({tag, " done_pulse"},     64'(bus.done),     64'd1);
                check({tag, " done_busy"},      64'(bus.busy),     64'd0);
                check({tag, " done_rd_valid"},  64'(bus.rd_valid), 64'd0);
                if (r.chk_p0) check({tag, " tbl_p0"}, got[0], r.exp_p0);
                if (r.chk_all) begin
                    n_bad = 0;
                    foreach (got[q]) if (got[q] != r.exp_all) n_bad++;
                    check({tag, " tbl_all_bad"}, 64'(n_bad), 64'd0);
                end
                @(posedge clk); #1;
                bus.arm = 1'b0; bus.trigger = 1'b1;
                @(negedge clk);
                check({tag, " done_one_cycle"}, 64'(bus.done), 64'd0);
                check({tag, " idle_after"},     64'(bus.busy), 64'd0);
                bus.trigger = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s timeout: got no done expected done within budget", tag);
        do_reset();
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0,  0, 0, 0, 0, 1'b1, 64'd0,  1'b0, 64'd0};
        tbl[1] = '{10, 0, 0, 0, 0, 1'b1, 64'd10, 1'b0, 64'd0};
        tbl[2] = '{0,  2, 1, 0, 0, 1'b0, 64'd0,  1'b1, 64'd10};
        tbl[3] = '{0,  3, 2, 0, 0, 1'b0, 64'd0,  1'b1, c_mask};
        tbl[4] = '{0,  0, 0, 1, 1, 1'b1, 64'd0,  1'b0, 64'd0};
        tbl[5] = '{5,  1, 3, 2, 1, 1'b0, 64'd0,  1'b0, 64'd0};
        tbl[6] = '{3,  3, 3, 2, 1, 1'b0, 64'd0,  1'b0, 64'd0};

        bus.sum_in = '0; bus.sum_valid = 1'b0; bus.arm = 1'b0; bus.trigger = 1'b0;
        bus.delay_cycles = '0; bus.avg_shift = '0; bus.rd_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset busy",     64'(bus.busy),     64'd0);
        check("reset done",     64'(bus.done),     64'd0);
        check("reset rd_valid", 64'(bus.rd_valid), 64'd0);
        check("reset rd_data",  64'(bus.rd_data),  64'd0);

        // Trigger while IDLE must not start anything.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.trigger = 1'b1;
            @(negedge clk);
            check("idle trigger busy", 64'(bus.busy), 64'd0);
        end
        bus.trigger = 1'b0;

        foreach (tbl[i]) run_capture(tbl[i], 0, 0, $sformatf("vec%0d", i));

        run_capture(tbl[5], 1, 100, "abort_cap");
        run_capture(tbl[0], 0, 0,   "after_abort_cap");
        run_capture(tbl[4], 2, 50,  "abort_ro");
        run_capture(tbl[2], 0, 0,   "after_abort_ro");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
